// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: each Step_In edge advances a rotate/ping-pong/blink pattern.
// Optional PWM dimming of the LED outputs is enabled by defining LED_PWM_EN.
module led_pattern_sequencer #(
   parameter int N_LEDS   = 4,
   parameter int PWM_BITS = 8
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic                Step_In,
   input  logic [1:0]          Mode,
   input  logic                Pause,
   input  logic [PWM_BITS-1:0] Brightness,
   output logic [N_LEDS-1:0]   LED_Out,
   output logic                Wrap_Pulse
);

   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

   localparam logic [1:0] MODE_ROT_L = 2'b00;
   localparam logic [1:0] MODE_ROT_R = 2'b01;
   localparam logic [1:0] MODE_PING  = 2'b10;
   localparam logic [1:0] MODE_BLINK = 2'b11;

   logic              step_d;
   logic              step;
   logic [1:0]        mode_q, mode_nxt;
   logic [N_LEDS-1:0] pat, pat_nxt;
   dir_t              dir, dir_nxt;
   logic              wrap_nxt;

   function automatic logic [N_LEDS-1:0] init_pat(input logic [1:0] m);
      init_pat = (m == MODE_BLINK) ? {N_LEDS{1'b1}} : {{(N_LEDS-1){1'b0}}, 1'b1};
   endfunction

   assign step = (Step_In ^ step_d) & ~Pause;

   always_ff @(posedge CLK) begin
      step_d <= Step_In;
      if (!RST_n) begin
         mode_q     <= Mode;
         pat        <= init_pat(Mode);
         dir        <= UP;
         Wrap_Pulse <= 1'b0;
      end else begin
         mode_q     <= mode_nxt;
         pat        <= pat_nxt;
         dir        <= dir_nxt;
         Wrap_Pulse <= wrap_nxt;
      end
   end

   // A mode change reloads the pattern and swallows any step landing in the same cycle.
   always_comb begin
      mode_nxt = mode_q;
      pat_nxt  = pat;
      dir_nxt  = dir;
      wrap_nxt = 1'b0;
      if (Mode != mode_q) begin
         mode_nxt = Mode;
         pat_nxt  = init_pat(Mode);
         dir_nxt  = UP;
      end else if (step) begin
         case (mode_q)
            MODE_ROT_L: pat_nxt = {pat[N_LEDS-2:0], pat[N_LEDS-1]};
            MODE_ROT_R: pat_nxt = {pat[0], pat[N_LEDS-1:1]};
            MODE_PING: begin
               // Reverse at the ends within the same step so no end pattern repeats.
               if (dir == UP) begin
                  if (pat[N_LEDS-1]) begin
                     dir_nxt = DOWN;
                     pat_nxt = {1'b0, pat[N_LEDS-1:1]};
                  end else begin
                     pat_nxt = {pat[N_LEDS-2:0], 1'b0};
                  end
               end else begin
                  if (pat[0]) begin
                     dir_nxt = UP;
                     pat_nxt = {pat[N_LEDS-2:0], 1'b0};
                  end else begin
                     pat_nxt = {1'b0, pat[N_LEDS-1:1]};
                  end
               end
            end
            default:    pat_nxt = ~pat;
         endcase
         wrap_nxt = (pat_nxt == init_pat(mode_q));
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         pwm_cnt <= '0;
         LED_Out <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         LED_Out <= pat & {N_LEDS{pwm_cnt < Brightness}};
      end
   end
`else
   logic unused_brightness;

   assign unused_brightness = ^Brightness;
   assign LED_Out           = pat;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer (default build, N_LEDS=4).
module tb_led_pattern_sequencer;

   logic       CLK = 1'b0;
   logic       RST_n;
   logic       Step_In;
   logic [1:0] Mode;
   logic       Pause;
   logic [7:0] Brightness;
   logic [3:0] LED_Out;
   logic       Wrap_Pulse;

   int testCount = 0;
   int failCount = 0;

   always #5 CLK = ~CLK;

   led_pattern_sequencer #(.N_LEDS(4), .PWM_BITS(8)) dut (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .Step_In    (Step_In),
      .Mode       (Mode),
      .Pause      (Pause),
      .Brightness (Brightness),
      .LED_Out    (LED_Out),
      .Wrap_Pulse (Wrap_Pulse)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Drive inputs just after a falling edge, then advance through one rising edge.
   task automatic applyStimulus(input logic step, input logic [1:0] mode, input logic pause);
      Step_In = step;
      Mode    = mode;
      Pause   = pause;
      @(negedge CLK);
   endtask

   task automatic checkLeds(input string tag, input logic [3:0] led, input logic wrap);
      checkOutput({tag, "_led"}, {4'b0, LED_Out}, {4'b0, led});
      checkOutput({tag, "_wrap"}, {7'b0, Wrap_Pulse}, {7'b0, wrap});
   endtask

   logic [3:0] rotSeq  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic       rotWrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [3:0] pingSeq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
   logic       pingWrap[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [3:0] prevLed;
      RST_n      = 1'b0;
      Step_In    = 1'b0;
      Mode       = 2'b00;
      Pause      = 1'b0;
      Brightness = 8'd0;
      applyStimulus(1'b0, 2'b00, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkLeds("reset", 4'b0001, 1'b0);
      RST_n = 1'b1;
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkLeds("after_release", 4'b0001, 1'b0);

      // Rotate left, one Step_In edge every 10 cycles
      prevLed = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         Step_In = ~Step_In;
         #1;
         checkOutput($sformatf("rotl_latency%0d", i), {4'b0, LED_Out}, {4'b0, prevLed});
         @(negedge CLK);
         checkLeds($sformatf("rotl_step%0d", i), rotSeq[i], rotWrap[i]);
         applyStimulus(Step_In, 2'b00, 1'b0);
         checkLeds($sformatf("rotl_hold%0d", i), rotSeq[i], 1'b0);
         repeat (8) @(negedge CLK);
         prevLed = rotSeq[i];
      end

      // Mode change to blink in the same cycle as a step edge
      applyStimulus(~Step_In, 2'b00, 1'b0);
      applyStimulus(~Step_In, 2'b00, 1'b0);
      checkLeds("rotl_at_0100", 4'b0100, 1'b0);
      applyStimulus(~Step_In, 2'b11, 1'b0);
      checkLeds("blink_modechg", 4'b1111, 1'b0);
      applyStimulus(Step_In, 2'b11, 1'b0);
      checkLeds("blink_idle", 4'b1111, 1'b0);
      applyStimulus(~Step_In, 2'b11, 1'b0);
      checkLeds("blink_off", 4'b0000, 1'b0);
      applyStimulus(~Step_In, 2'b11, 1'b0);
      checkLeds("blink_on_wrap", 4'b1111, 1'b1);
      applyStimulus(Step_In, 2'b11, 1'b0);
      checkLeds("blink_wrap_clear", 4'b1111, 1'b0);

      // Ping-pong through a full period plus one
      applyStimulus(Step_In, 2'b10, 1'b0);
      checkLeds("ping_init", 4'b0001, 1'b0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(~Step_In, 2'b10, 1'b0);
         checkLeds($sformatf("ping_step%0d", i), pingSeq[i], pingWrap[i]);
      end

      // Paused edges are discarded, not queued
      for (int i = 0; i < 3; i++) begin
         applyStimulus(~Step_In, 2'b10, 1'b1);
         checkLeds($sformatf("pause_hold%0d", i), 4'b0010, 1'b0);
      end
      applyStimulus(Step_In, 2'b10, 1'b0);
      checkLeds("unpause_idle", 4'b0010, 1'b0);
      applyStimulus(~Step_In, 2'b10, 1'b0);
      checkLeds("unpause_step", 4'b0100, 1'b0);
      applyStimulus(Step_In, 2'b10, 1'b0);
      checkLeds("unpause_settle", 4'b0100, 1'b0);

      // Reset mid-run with Step_In held high
      applyStimulus(Step_In, 2'b00, 1'b0);
      checkLeds("rst_pre_init", 4'b0001, 1'b0);
      applyStimulus(~Step_In, 2'b00, 1'b0);
      applyStimulus(~Step_In, 2'b00, 1'b0);
      checkLeds("rst_pre_run", 4'b0100, 1'b0);
      RST_n = 1'b0;
      applyStimulus(1'b1, 2'b00, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0);
      checkLeds("rst_mid", 4'b0001, 1'b0);
      RST_n = 1'b1;
      applyStimulus(1'b1, 2'b00, 1'b0);
      checkLeds("rst_release0", 4'b0001, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0);
      checkLeds("rst_release1", 4'b0001, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkLeds("rst_first_step", 4'b0010, 1'b0);

      // Rotate right wraps from 0010 to 0001
      applyStimulus(1'b0, 2'b01, 1'b0);
      checkLeds("rotr_init", 4'b0001, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0);
      checkLeds("rotr_step0", 4'b1000, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0);
      checkLeds("rotr_step2", 4'b0010, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b0);
      checkLeds("rotr_wrap", 4'b0001, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
